// File: rtl/qspi_sclk_gen.sv
// QSPI serial-clock generator: programmable SCLK divider with CPOL/CPHA-aware
// launch/sample strobes, burst length control, abort and done signalling.
module qspi_sclk_gen #(
  parameter int DIV_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             io_start_signal,
  input  logic             io_stop,
  input  logic [DIV_W-1:0] io_cchan_divide,
  input  logic             io_cpol,
  input  logic             io_cpha,
  input  logic [CNT_W-1:0] io_num_cycles,
  output logic             io_sclk,
  output logic             io_launch_en,
  output logic             io_sample_en,
  output logic             io_busy,
  output logic             io_done
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   EDGE_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_e           state_q;
  logic [DIV_W-1:0] divide_q;
  logic [DIV_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W:0]   edge_cnt_q;
  logic             cpol_q;
  logic             cpha_q;
  logic             sclk_q;
  logic             busy_q;
  logic             done_q;

  logic start_ok;
  logic edge_ev;
  logic leading;
  logic last_edge;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    start_ok     = (state_q == IDLE) && io_start_signal && (io_num_cycles != '0);
    edge_ev      = (state_q == RUN) && (div_cnt_q == '0);
    leading      = (sclk_q == cpol_q);
    last_edge    = (edge_cnt_q == ({num_q, 1'b0} - EDGE_ONE));
    io_launch_en = 1'b0;
    io_sample_en = 1'b0;
    if (rst_n) begin
      if (start_ok) begin
        io_launch_en = !io_cpha;
      end else if (edge_ev && !io_stop) begin
        if (cpha_q) begin
          io_launch_en = leading;
          io_sample_en = !leading;
        end else begin
          // The final trailing edge closes the burst, so nothing is launched on it.
          io_sample_en = leading;
          io_launch_en = !leading && !last_edge;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= io_cpol;
          if (start_ok) begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            div_cnt_q  <= io_cchan_divide;
            edge_cnt_q <= '0;
          end else if (io_start_signal) begin
            done_q <= 1'b1;
          end
        end
        RUN: begin
          if (io_stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            sclk_q  <= cpol_q;
          end else if (div_cnt_q == '0) begin
            div_cnt_q  <= divide_q;
            edge_cnt_q <= edge_cnt_q + EDGE_ONE;
            if (last_edge) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sclk_q  <= cpol_q;
            end else begin
              sclk_q <= ~sclk_q;
            end
          end else begin
            div_cnt_q <= div_cnt_q - DIV_ONE;
          end
        end
      endcase
    end
  end

  // NOTE: burst configuration is only read in RUN, after a start has loaded it,
  // so these registers need no reset.
  always_ff @(posedge clock) begin
    if (start_ok) begin
      divide_q <= io_cchan_divide;
      cpol_q   <= io_cpol;
      cpha_q   <= io_cpha;
      num_q    <= io_num_cycles;
    end
  end

  assign io_sclk = sclk_q;
  assign io_busy = busy_q;
  assign io_done = done_q;

endmodule

// File: tb/tb_qspi_sclk_gen.sv
// Directed bench for qspi_sclk_gen: per-cycle vector table for mode 0 plus
// hand sequences for mode 3, abort, zero-length burst, reset and wide counts.
module tb_qspi_sclk_gen;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] divide;
  logic        cpol;
  logic        cpha;
  logic [7:0]  num;
  logic        sclk, launch, sample, busy, done;

  logic        w_start;
  logic [3:0]  w_divide;
  logic [7:0]  w_num;
  logic        w_sclk, w_launch, w_sample, w_busy, w_done;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  qspi_sclk_gen u_dut (
    .clock          (clock),
    .rst_n          (rst_n),
    .io_start_signal(start),
    .io_stop        (stop),
    .io_cchan_divide(divide),
    .io_cpol        (cpol),
    .io_cpha        (cpha),
    .io_num_cycles  (num),
    .io_sclk        (sclk),
    .io_launch_en   (launch),
    .io_sample_en   (sample),
    .io_busy        (busy),
    .io_done        (done)
  );

  qspi_sclk_gen #(.DIV_W(4), .CNT_W(8)) u_wide (
    .clock          (clock),
    .rst_n          (rst_n),
    .io_start_signal(w_start),
    .io_stop        (stop),
    .io_cchan_divide(w_divide),
    .io_cpol        (cpol),
    .io_cpha        (cpha),
    .io_num_cycles  (w_num),
    .io_sclk        (w_sclk),
    .io_launch_en   (w_launch),
    .io_sample_en   (w_sample),
    .io_busy        (w_busy),
    .io_done        (w_done)
  );

  // Expected output vector packs {sclk, launch, sample, busy, done}.
  typedef struct {
    logic        start;
    logic        stop;
    logic [15:0] divide;
    logic        cpol;
    logic        cpha;
    logic [7:0]  num;
    logic [4:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic st, input logic [15:0] d,
                              input logic cp, input logic ch, input logic [7:0] n,
                              input logic [4:0] e);
    vec_t v;
    v.start = s; v.stop = st; v.divide = d; v.cpol = cp; v.cpha = ch; v.num = n; v.exp = e;
    return v;
  endfunction

  function automatic logic [4:0] obs();
    return {sclk, launch, sample, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then compare just after.
  task automatic cyc(input logic s, input logic st, input logic [15:0] d, input logic cp,
                     input logic ch, input logic [7:0] n, input string name,
                     input logic [4:0] e);
    @(negedge clock);
    rst_n = 1'b1; start = s; stop = st; divide = d; cpol = cp; cpha = ch; num = n;
    #1;
    check(name, 32'(obs()), 32'(e));
  endtask

  logic [4:0] m0 [11] = '{5'b01000, 5'b00010, 5'b00110, 5'b10010, 5'b11010, 5'b00010,
                         5'b00110, 5'b10010, 5'b10010, 5'b00001, 5'b00000};

  int launches, samples, done_cnt, done_cycle, run, high_runs, bad_runs, overlap;

  initial begin
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; divide = 16'd1;
    cpol = 1'b0; cpha = 1'b0; num = 8'd2;
    w_start = 1'b0; w_divide = 4'd0; w_num = 8'd0;

    // Mode 0 burst, then the same burst with start held and divide changed mid-run.
    for (int k = 0; k < 11; k++)
      vecs.push_back(mk(k == 0, 1'b0, 16'd1, 1'b0, 1'b0, 8'd2, m0[k]));
    for (int k = 0; k < 11; k++)
      vecs.push_back(mk(k <= 8, 1'b0, (k == 0 || k > 8) ? 16'd1 : 16'd7,
                        1'b0, 1'b0, 8'd2, m0[k]));

    // Reset held with start asserted: all outputs and strobes low.
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      #1;
      check($sformatf("reset_%0d", k), 32'(obs()), 32'd0);
    end

    for (int i = 0; i < vecs.size(); i++)
      cyc(vecs[i].start, vecs[i].stop, vecs[i].divide, vecs[i].cpol, vecs[i].cpha,
          vecs[i].num, $sformatf("table_%0d", i), vecs[i].exp);

    // Mode 3: divide=0, cpol=1, cpha=1, N=3.
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 8'd3, "m3_idle", 5'b00000);
    cyc(1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 8'd3, "m3_c0", 5'b10000);
    for (int k = 1; k <= 6; k++)
      cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 8'd3, $sformatf("m3_c%0d", k),
          {(k % 2 == 1), (k % 2 == 1), (k % 2 == 0), 1'b1, 1'b0});
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b1, 8'd3, "m3_done", 5'b10001);

    // Abort on a leading edge, then a fresh one-cycle burst.
    cyc(1'b1, 1'b0, 16'd1, 1'b1, 1'b0, 8'd4, "ab_c0", 5'b11000);
    cyc(1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 8'd4, "ab_c1", 5'b10010);
    cyc(1'b0, 1'b1, 16'd1, 1'b1, 1'b0, 8'd4, "ab_stop", 5'b10010);
    cyc(1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 8'd4, "ab_idle", 5'b10000);
    cyc(1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 8'd1, "ab_restart", 5'b11000);
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'd1, "ab_sample", 5'b10110);
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'd1, "ab_last", 5'b00010);
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'd1, "ab_done", 5'b10001);
    cyc(1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 8'd1, "ab_after", 5'b10000);

    // Zero-length start: no strobes, no busy, done one cycle later.
    cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 8'd0, "n0_start", 5'b10000);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'd0, "n0_done", 5'b00001);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 8'd0, "n0_after", 5'b00000);

    // Reset mid-burst with cpol=1, landing on an edge-event cycle.
    cyc(1'b1, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_c0", 5'b01000);
    cyc(1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_c1", 5'b10010);
    cyc(1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_c2", 5'b10010);
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    check("rs_assert", 32'(obs()), 32'(5'b10010));
    cyc(1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_after", 5'b00000);
    cyc(1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_idle1", 5'b10000);
    cyc(1'b0, 1'b0, 16'd2, 1'b1, 1'b0, 8'd3, "rs_idle2", 5'b10000);

    // Wide instance: divide=15, N=255 -> edges every 16 cycles, done at cycle 8161.
    @(negedge clock);
    cpol = 1'b0; cpha = 1'b0; stop = 1'b0; start = 1'b0;
    @(negedge clock);
    w_start = 1'b1; w_divide = 4'd15; w_num = 8'd255;
    #1;
    launches = int'(w_launch); samples = int'(w_sample);
    done_cnt = 0; done_cycle = -1; run = 0; high_runs = 0; bad_runs = 0; overlap = 0;
    for (int c = 1; c <= 8200; c++) begin
      @(negedge clock);
      w_start = 1'b0; w_divide = 4'd3;
      #1;
      if (c == 1) check("w_busy", 32'(w_busy), 32'd1);
      launches += int'(w_launch);
      samples  += int'(w_sample);
      if (w_launch && w_sample) overlap++;
      if (w_done) begin
        done_cnt++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (w_sclk) run++;
      else if (run != 0) begin
        high_runs++;
        if (run != 16) bad_runs++;
        run = 0;
      end
    end
    check("w_done_cycle", done_cycle, 8161);
    check("w_done_count", done_cnt, 1);
    check("w_launches", launches, 255);
    check("w_samples", samples, 255);
    check("w_high_runs", high_runs, 255);
    check("w_bad_runs", bad_runs, 0);
    check("w_overlap", overlap, 0);
    check("w_busy_end", 32'(w_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
